// File: rtl/pingpong_buffer_memory.sv
// Double-buffered banked SRAM buffer: a serial port fills one half while full
// D-word rows stream out of the other; halves swap when fill is full and drain released.
module pingpong_buffer_memory #(
  parameter int unsigned depth = 2,
  parameter int unsigned A     = 7,
  parameter int unsigned W     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     fillStart,
  input  logic [A:0]               fillRows,
  input  logic [W-1:0]             ioInput,
  input  logic                     ioValid,
  output logic                     ioReady,
  input  logic                     rdStart,
  input  logic [A:0]               rdRows,
  input  logic                     rdReuse,
  output logic [(W << depth)-1:0]  op,
  output logic                     opValid,
  output logic                     opLast,
  output logic                     fillHalf,
  output logic                     fillFull,
  output logic                     drainReady
);

  localparam int unsigned D    = 1 << depth;
  localparam int unsigned ROWS = 1 << A;

  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_FULL} fstate_t;
  typedef enum logic [1:0] {R_EMPTY, R_READY, R_READ} dstate_t;

  fstate_t fstate, fstate_nx;
  dstate_t dstate, dstate_nx;

  logic [depth-1:0] bank_cnt;
  logic [A-1:0]     addr_cnt;
  logic [A:0]       fill_rows;
  logic [A-1:0]     rd_addr;
  logic [A:0]       rd_rows;
  logic             rd_reuse;

  logic             fill_start_ok, wr_en, wr_last, swap;
  logic             rd_start_ok, rd_en, rd_last, drain_half;
  logic             io_ready_nx, fill_full_nx, drain_ready_nx, op_valid_nx, op_last_nx;

  logic [W-1:0] mem [2][D][ROWS];

  // Handshake and end-of-transfer decode
  always_comb begin
    fill_start_ok = (fstate == F_IDLE) && fillStart && (fillRows != '0);
    wr_en         = (fstate == F_LOAD) && ioValid && !RST;
    wr_last       = wr_en && (bank_cnt == depth'(D - 1)) &&
                    ({1'b0, addr_cnt} == fill_rows - (A+1)'(1));
    swap          = (fstate == F_FULL) && (dstate == R_EMPTY);
    rd_start_ok   = (dstate == R_READY) && rdStart && (rdRows != '0);
    rd_en         = (dstate == R_READ) && !RST;
    rd_last       = (dstate == R_READ) && ({1'b0, rd_addr} == rd_rows - (A+1)'(1));
    drain_half    = ~fillHalf;
  end

  // Next-state logic for both FSMs
  always_comb begin
    fstate_nx = fstate;
    dstate_nx = dstate;
    case (fstate)
      F_IDLE:  if (fill_start_ok) fstate_nx = F_LOAD;
      F_LOAD:  if (wr_last)       fstate_nx = F_FULL;
      F_FULL:  if (swap)          fstate_nx = F_IDLE;
      default:                    fstate_nx = F_IDLE;
    endcase
    case (dstate)
      R_EMPTY: if (swap)          dstate_nx = R_READY;
      R_READY: if (rd_start_ok)   dstate_nx = R_READ;
      R_READ:  if (rd_last)       dstate_nx = rd_reuse ? R_READY : R_EMPTY;
      default:                    dstate_nx = R_EMPTY;
    endcase
  end

  // Next values of the registered status outputs
  always_comb begin
    io_ready_nx    = (fstate_nx == F_LOAD);
    fill_full_nx   = (fstate_nx == F_FULL);
    drain_ready_nx = (dstate_nx == R_READY);
    op_valid_nx    = (dstate == R_READ);
    op_last_nx     = rd_last;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fstate     <= F_IDLE;
      dstate     <= R_EMPTY;
      fillHalf   <= 1'b0;
      bank_cnt   <= '0;
      addr_cnt   <= '0;
      fill_rows  <= '0;
      rd_addr    <= '0;
      rd_rows    <= '0;
      rd_reuse   <= 1'b0;
      ioReady    <= 1'b0;
      fillFull   <= 1'b0;
      drainReady <= 1'b0;
      opValid    <= 1'b0;
      opLast     <= 1'b0;
    end else begin
      fstate     <= fstate_nx;
      dstate     <= dstate_nx;
      ioReady    <= io_ready_nx;
      fillFull   <= fill_full_nx;
      drainReady <= drain_ready_nx;
      opValid    <= op_valid_nx;
      opLast     <= op_last_nx;
      if (swap) fillHalf <= ~fillHalf;
      if (fill_start_ok) begin
        fill_rows <= fillRows;
        bank_cnt  <= '0;
        addr_cnt  <= '0;
      end else if (wr_en) begin
        bank_cnt <= bank_cnt + depth'(1);
        if (bank_cnt == depth'(D - 1)) addr_cnt <= addr_cnt + A'(1);
      end
      if (rd_start_ok) begin
        rd_rows  <= rdRows;
        rd_reuse <= rdReuse;
        rd_addr  <= '0;
      end else if (dstate == R_READ) begin
        rd_addr <= rd_addr + A'(1);
      end
    end
  end

  // Fill-half bank write; contents are never cleared
  always_ff @(posedge CLK) begin
    if (wr_en) mem[fillHalf][bank_cnt][addr_cnt] <= ioInput;
  end

  // Registered parallel read of all drain-half banks; op holds between rows
  always_ff @(posedge CLK) begin
    if (RST) begin
      op <= '0;
    end else if (rd_en) begin
      for (int unsigned i = 0; i < D; i++) op[W*i +: W] <= mem[drain_half][depth'(i)][rd_addr];
    end
  end

endmodule

// File: tb/tb_pingpong_buffer_memory.sv
// Self-checking bench for pingpong_buffer_memory: command table, directed
// sequences and randomized loads/streams checked against an array model.
module tb_pingpong_buffer_memory;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 7;
  localparam int unsigned WW    = 16;
  localparam int unsigned D     = 1 << DEPTH;
  localparam int unsigned ROWS  = 1 << AW;
  localparam int unsigned OPW   = WW * D;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            fillStart = 1'b0;
  logic [AW:0]     fillRows = '0;
  logic [WW-1:0]   ioInput = '0;
  logic            ioValid = 1'b0;
  logic            ioReady;
  logic            rdStart = 1'b0;
  logic [AW:0]     rdRows = '0;
  logic            rdReuse = 1'b0;
  logic [OPW-1:0]  op;
  logic            opValid, opLast, fillHalf, fillFull, drainReady;

  pingpong_buffer_memory #(.depth(DEPTH), .A(AW), .W(WW)) dut (
    .CLK(CLK), .RST(RST), .fillStart(fillStart), .fillRows(fillRows),
    .ioInput(ioInput), .ioValid(ioValid), .ioReady(ioReady),
    .rdStart(rdStart), .rdRows(rdRows), .rdReuse(rdReuse),
    .op(op), .opValid(opValid), .opLast(opLast),
    .fillHalf(fillHalf), .fillFull(fillFull), .drainReady(drainReady)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: contents of both halves and which half is being filled
  logic [WW-1:0] mm [2][D][ROWS];
  bit            mfh = 1'b0;
  logic [63:0]   got [ROWS];

  typedef struct {
    bit          fs;
    logic [AW:0] fr;
    bit          rs;
    logic [AW:0] rr;
    bit          e_ior;
    bit          e_full;
    bit          e_drdy;
    bit          e_ov;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mrow(input bit h, input int r);
    logic [63:0] res = '0;
    for (int i = 0; i < int'(D); i++) res[WW*i +: WW] = mm[h][i][r];
    return res;
  endfunction

  // Load D*rows words into the fill half; optional idle gaps and counting data
  task automatic load(input int rows, input bit gaps, input bit do_start, input bit seq);
    int nw = int'(D) * rows;
    int k = 0;
    int cyc = 0;
    bit v;
    logic [WW-1:0] d;
    if (do_start) begin
      fillStart = 1'b1;
      fillRows  = (AW+1)'(rows);
      tick();
      fillStart = 1'b0;
    end
    while (k < nw && cyc < 4 * nw + 20) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = seq ? WW'(k + 1) : WW'($urandom);
      ioValid = v;
      ioInput = d;
      chk("ioready_during_load", ioReady, 1);
      tick();
      cyc++;
      if (v) begin
        mm[mfh][k % int'(D)][k / int'(D)] = d;
        k++;
      end
    end
    ioValid = 1'b0;
    chk("load_words_accepted", k, nw);
    chk("fillfull_after_load", fillFull, 1);
    chk("ioready_after_load", ioReady, 0);
  endtask

  task automatic expect_swap();
    tick();
    mfh = ~mfh;
    chk("swap_fillhalf", fillHalf, mfh);
    chk("swap_drainready", drainReady, 1);
    chk("swap_fillfull", fillFull, 0);
  endtask

  // Stream rows from the drain half and compare each row with the model
  task automatic stream(input int rows, input bit reuse);
    rdStart = 1'b1;
    rdRows  = (AW+1)'(rows);
    rdReuse = reuse;
    tick();
    rdStart = 1'b0;
    rdReuse = 1'b0;
    chk("opvalid_before_first_row", opValid, 0);
    for (int k = 0; k < rows; k++) begin
      tick();
      got[k] = op;
      chk("row_valid", opValid, 1);
      chk("row_data", op, mrow(~mfh, k));
      chk("row_last", opLast, k == rows - 1);
    end
    chk("drainready_after_stream", drainReady, reuse);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [WW-1:0] d;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};  // fillRows=0 ignored
    tbl[1] = '{0, 0, 1, 2, 0, 0, 0, 0};  // rdStart while drain empty
    tbl[2] = '{0, 0, 1, 0, 0, 0, 0, 0};  // rdRows=0
    tbl[3] = '{1, 3, 0, 0, 1, 0, 0, 0};  // accepted: load 3 rows
    tbl[4] = '{1, 1, 0, 0, 1, 0, 0, 0};  // fillStart during load ignored
    tbl[5] = '{0, 0, 1, 1, 1, 0, 0, 0};  // rdStart still ignored

    // Reset values
    tick();
    tick();
    chk("rst_ioready", ioReady, 0);
    chk("rst_op", op, 0);
    chk("rst_opvalid", opValid, 0);
    chk("rst_oplast", opLast, 0);
    chk("rst_fillhalf", fillHalf, 0);
    chk("rst_fillfull", fillFull, 0);
    chk("rst_drainready", drainReady, 0);
    RST = 1'b0;
    tick();

    // Basic load of 1..8, swap, stream two rows
    load(2, 1'b0, 1'b1, 1'b1);
    expect_swap();
    stream(2, 1'b0);
    chk("t1_row0_const", got[0], 64'h0004_0003_0002_0001);
    chk("t1_row1_const", got[1], 64'h0008_0007_0006_0005);

    // Command table: ignored commands and one accepted load
    for (int i = 0; i < 6; i++) begin
      fillStart = tbl[i].fs;
      fillRows  = tbl[i].fr;
      rdStart   = tbl[i].rs;
      rdRows    = tbl[i].rr;
      tick();
      fillStart = 1'b0;
      rdStart   = 1'b0;
      chk($sformatf("tbl%0d_ioready", i), ioReady, tbl[i].e_ior);
      chk($sformatf("tbl%0d_fillfull", i), fillFull, tbl[i].e_full);
      chk($sformatf("tbl%0d_drainready", i), drainReady, tbl[i].e_drdy);
      chk($sformatf("tbl%0d_opvalid", i), opValid, tbl[i].e_ov);
    end
    load(3, 1'b1, 1'b0, 1'b0);
    expect_swap();

    // Concurrent fill and reuse streaming; no swap while drain holds its half
    fork
      stream(3, 1'b1);
      load(1, 1'b1, 1'b1, 1'b0);
    join
    tick();
    chk("no_swap_fillhalf", fillHalf, mfh);
    chk("no_swap_fillfull", fillFull, 1);
    chk("no_swap_drainready", drainReady, 1);
    stream(3, 1'b1);
    stream(3, 1'b0);
    expect_swap();
    stream(1, 1'b0);

    // Full row range with gaps: counter wrap over all 128 rows
    load(int'(ROWS), 1'b1, 1'b1, 1'b0);
    expect_swap();
    stream(int'(ROWS), 1'b1);

    // Reset in the middle of a load and a stream
    fillStart = 1'b1;
    fillRows  = (AW+1)'(2);
    tick();
    fillStart = 1'b0;
    for (int j = 0; j < 3; j++) begin
      d = WW'($urandom);
      ioValid = 1'b1;
      ioInput = d;
      tick();
      mm[mfh][j][0] = d;
    end
    ioValid = 1'b0;
    rdStart = 1'b1;
    rdRows  = (AW+1)'(ROWS);
    rdReuse = 1'b1;
    tick();
    rdStart = 1'b0;
    rdReuse = 1'b0;
    repeat (4) tick();
    chk("midstream_opvalid", opValid, 1);
    chk("midstream_row3", op, mrow(~mfh, 3));
    RST = 1'b1;
    ioValid = 1'b1;
    ioInput = WW'($urandom);
    tick();
    RST = 1'b0;
    ioValid = 1'b0;
    chk("mid_rst_ioready", ioReady, 0);
    chk("mid_rst_op", op, 0);
    chk("mid_rst_opvalid", opValid, 0);
    chk("mid_rst_oplast", opLast, 0);
    chk("mid_rst_fillhalf", fillHalf, 0);
    chk("mid_rst_fillfull", fillFull, 0);
    chk("mid_rst_drainready", drainReady, 0);
    mfh = 1'b0;
    tick();
    chk("post_rst_opvalid", opValid, 0);
    chk("post_rst_ioready", ioReady, 0);

    // Reload counters only: older contents of half 1 remain readable
    load(1, 1'b0, 1'b1, 1'b0);
    expect_swap();
    stream(1, 1'b0);
    load(1, 1'b1, 1'b1, 1'b0);
    expect_swap();
    stream(int'(ROWS), 1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
